// File: rtl/ren_conv_pkg.sv
// Shared definitions for the convolver: address regions, register map, field positions, config structs.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package ren_conv_pkg;

  typedef enum logic [1:0] {
    REGION_REG  = 2'd0,
    REGION_IMG  = 2'd1,
    REGION_KERN = 2'd2,
    REGION_RSLT = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_POOL,
    ST_DONE
  } state_e;

  // Instance number is adr[31:24] minus this base.
  localparam logic [7:0] INST_BASE = 8'h30;

  // Register word offsets within the register region.
  localparam logic [5:0] REG_CTRL = 6'd0;
  localparam logic [5:0] REG_CFG0 = 6'd1;
  localparam logic [5:0] REG_CFG1 = 6'd2;

  // Field bit positions.
  localparam int CTRL_DONE_BIT  = 0;
  localparam int CTRL_SRST_BIT  = 1;
  localparam int CTRL_START_BIT = 2;
  localparam int CFG0_KCOLS_LSB  = 0;
  localparam int CFG0_COLS_LSB   = 8;
  localparam int CFG0_KERNS_LSB  = 16;
  localparam int CFG0_STRIDE_LSB = 24;
  localparam int CFG1_RCOLS_LSB = 0;
  localparam int CFG1_SHIFT_LSB = 8;
  localparam int CFG1_KAM_BIT   = 16;
  localparam int CFG1_MP_BIT    = 17;
  localparam int CFG1_MASK_LSB  = 18;

  // Worst case 3 ch * 8 taps * 255*255 needs 21 bits; keep headroom.
  localparam int ACC_W = 24;

  typedef struct packed {
    logic [7:0] stride;
    logic [2:0] kerns_m1;
    logic [7:0] cols_m1;
    logic [2:0] kcols_m1;
  } cfg0_t;

  typedef struct packed {
    logic [2:0] mask;
    logic       mp;
    logic       kam;
    logic [3:0] shift;
    logic [7:0] rcols_m1;
  } cfg1_t;

  // Masked three-channel dot product of one image word and one kernel word.
  function automatic logic [17:0] dot3(input logic [23:0] a, input logic [23:0] b,
                                       input logic [2:0] mask);
    logic [17:0] s;
    s = '0;
    for (int ch = 0; ch < 3; ch++) begin
      if (mask[ch]) s = s + 18'(a[ch*8 +: 8]) * 18'(b[ch*8 +: 8]);
    end
    return s;
  endfunction

endpackage

// File: rtl/ren_conv_engine.sv
// One convolver: config/control registers, image/kernel/result memories and the compute FSM.
// Latency: host reads are combinational (wrapper registers them); a job takes kerns*cols*kern_cols+2 cycles.
// Backpressure: none; host accesses are always accepted and take priority over the engine.
// Ports: i_clk/i_rst clock and sync reset; i_acc_vld/i_we/i_region/i_idx/i_wdat host access; o_rdat read data.
module ren_conv_engine
  import ren_conv_pkg::*;
#(
  parameter int IMG_ADDR_WIDTH  = 6,
  parameter int RSLT_ADDR_WIDTH = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_acc_vld,
  input  logic        i_we,
  input  region_e     i_region,
  input  logic [5:0]  i_idx,
  input  logic [31:0] i_wdat,
  output logic [31:0] o_rdat
);

  logic [23:0] r_img  [2**IMG_ADDR_WIDTH];
  logic [23:0] r_kern [2**IMG_ADDR_WIDTH];
  logic [7:0]  r_rslt [2**RSLT_ADDR_WIDTH];

  state_e r_state, w_nxt;
  logic   r_start, r_srst;
  cfg0_t  r_cfg0;
  cfg1_t  r_cfg1;

  logic [2:0]       r_kc, r_ks, r_wb_ks;
  logic [7:0]       r_c, r_wb_c;
  logic [ACC_W-1:0] r_acc, r_wb_val, r_prev;
  logic             r_wb_vld;

  logic w_busy, w_last_kc, w_last_c, w_last_ks;
  assign w_busy    = (r_state == ST_RUN) || (r_state == ST_POOL);
  assign w_last_kc = (r_kc == r_cfg0.kcols_m1);
  assign w_last_c  = (r_c == r_cfg0.cols_m1);
  assign w_last_ks = (r_ks == r_cfg0.kerns_m1);

  // Host side: registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_start <= 1'b0;
      r_srst  <= 1'b0;
      r_cfg0  <= '0;
      r_cfg1  <= '0;
    end else if (i_acc_vld && i_we && i_region == REGION_REG) begin
      case (i_idx)
        REG_CTRL: begin
          r_srst <= i_wdat[CTRL_SRST_BIT];
          if (!w_busy) r_start <= i_wdat[CTRL_START_BIT];
        end
        REG_CFG0: begin
          r_cfg0.kcols_m1 <= i_wdat[CFG0_KCOLS_LSB +: 3];
          r_cfg0.cols_m1  <= i_wdat[CFG0_COLS_LSB +: 8];
          r_cfg0.kerns_m1 <= i_wdat[CFG0_KERNS_LSB +: 3];
          r_cfg0.stride   <= i_wdat[CFG0_STRIDE_LSB +: 8];
        end
        REG_CFG1: begin
          r_cfg1.rcols_m1 <= i_wdat[CFG1_RCOLS_LSB +: 8];
          r_cfg1.shift    <= i_wdat[CFG1_SHIFT_LSB +: 4];
          r_cfg1.kam      <= i_wdat[CFG1_KAM_BIT];
          r_cfg1.mp       <= i_wdat[CFG1_MP_BIT];
          r_cfg1.mask     <= i_wdat[CFG1_MASK_LSB +: 3];
        end
        default: ;
      endcase
    end
  end

  // Host side: image/kernel memories (never reset). Result region writes are dropped.
  always_ff @(posedge i_clk) begin
    if (i_acc_vld && i_we) begin
      if (i_region == REGION_IMG)  r_img[IMG_ADDR_WIDTH'(i_idx)]  <= i_wdat[23:0];
      if (i_region == REGION_KERN) r_kern[IMG_ADDR_WIDTH'(i_idx)] <= i_wdat[23:0];
    end
  end

  always_comb begin
    o_rdat = '0;
    case (i_region)
      REGION_REG: begin
        case (i_idx)
          REG_CTRL: begin
            o_rdat[CTRL_DONE_BIT]  = (r_state == ST_DONE);
            o_rdat[CTRL_SRST_BIT]  = r_srst;
            o_rdat[CTRL_START_BIT] = r_start;
          end
          REG_CFG0: begin
            o_rdat[CFG0_KCOLS_LSB +: 3]  = r_cfg0.kcols_m1;
            o_rdat[CFG0_COLS_LSB +: 8]   = r_cfg0.cols_m1;
            o_rdat[CFG0_KERNS_LSB +: 3]  = r_cfg0.kerns_m1;
            o_rdat[CFG0_STRIDE_LSB +: 8] = r_cfg0.stride;
          end
          REG_CFG1: begin
            o_rdat[CFG1_RCOLS_LSB +: 8] = r_cfg1.rcols_m1;
            o_rdat[CFG1_SHIFT_LSB +: 4] = r_cfg1.shift;
            o_rdat[CFG1_KAM_BIT]        = r_cfg1.kam;
            o_rdat[CFG1_MP_BIT]         = r_cfg1.mp;
            o_rdat[CFG1_MASK_LSB +: 3]  = r_cfg1.mask;
          end
          default: ;
        endcase
      end
      REGION_IMG:  o_rdat = {8'h00, r_img[IMG_ADDR_WIDTH'(i_idx)]};
      REGION_KERN: o_rdat = {8'h00, r_kern[IMG_ADDR_WIDTH'(i_idx)]};
      REGION_RSLT: o_rdat = {24'h0, r_rslt[RSLT_ADDR_WIDTH'(i_idx)]};
      default: ;
    endcase
  end

  // Compute FSM. Soft reset is a level: while set the engine is held idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (r_start)                        w_nxt = ST_RUN;
      ST_RUN:  if (w_last_kc && w_last_c && w_last_ks) w_nxt = ST_POOL;
      ST_POOL:                                      w_nxt = ST_DONE;
      ST_DONE: if (!r_start)                       w_nxt = ST_IDLE;
      default:                                      w_nxt = ST_IDLE;
    endcase
    if (r_srst) w_nxt = ST_IDLE;
  end

  // One kernel tap per cycle, all enabled channels in parallel.
  logic [16:0] w_img_full;
  logic [11:0] w_kern_full;
  logic [17:0] w_prod;
  logic [ACC_W-1:0] w_conv;
  assign w_img_full  = 17'(r_c) * 17'(r_cfg0.stride) + 17'(r_kc);
  assign w_kern_full = (r_cfg1.kam ? (12'(r_ks) << 3) : (12'(r_ks) << 2)) + 12'(r_kc);
  assign w_prod = dot3(r_img[IMG_ADDR_WIDTH'(w_img_full)], r_kern[IMG_ADDR_WIDTH'(w_kern_full)],
                       r_cfg1.mask);
  assign w_conv = r_acc + ACC_W'(w_prod);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_kc <= '0; r_c <= '0; r_ks <= '0; r_acc <= '0;
      r_wb_vld <= 1'b0; r_wb_val <= '0; r_wb_ks <= '0; r_wb_c <= '0; r_prev <= '0;
    end else begin
      r_wb_vld <= 1'b0;
      if (r_state == ST_RUN && !r_srst) begin
        if (w_last_kc) begin
          r_acc    <= '0;
          r_kc     <= '0;
          r_wb_vld <= 1'b1;
          r_wb_val <= w_conv;
          r_wb_ks  <= r_ks;
          r_wb_c   <= r_c;
          if (w_last_c) begin
            r_c  <= '0;
            r_ks <= r_ks + 3'd1;
          end else begin
            r_c <= r_c + 8'd1;
          end
        end else begin
          r_acc <= w_conv;
          r_kc  <= r_kc + 3'd1;
        end
      end else begin
        r_kc <= '0; r_c <= '0; r_ks <= '0; r_acc <= '0;
      end
      // Even column of a pooled pair is parked until its odd partner arrives.
      if (r_wb_vld && r_cfg1.mp && !r_wb_c[0]) r_prev <= r_wb_val;
    end
  end

  // Writeback stage: one cycle behind the MAC; POOL exists to drain the final entry.
  logic [8:0]       w_ncols, w_base;
  logic [7:0]       w_col;
  logic [11:0]      w_rs_full;
  logic [ACC_W-1:0] w_rs_val;
  logic             w_rs_we;
  assign w_ncols   = 9'(r_cfg0.cols_m1) + 9'd1;
  assign w_base    = r_cfg1.mp ? (w_ncols >> 1) : w_ncols;
  assign w_col     = r_cfg1.mp ? (r_wb_c >> 1) : r_wb_c;
  assign w_rs_full = 12'(r_wb_ks) * 12'(w_base) + 12'(w_col);
  assign w_rs_val  = (r_cfg1.mp && r_prev > r_wb_val) ? r_prev : r_wb_val;
  assign w_rs_we   = r_wb_vld && !r_srst && (!r_cfg1.mp || r_wb_c[0]);

  always_ff @(posedge i_clk) begin
    if (w_rs_we) r_rslt[RSLT_ADDR_WIDTH'(w_rs_full)] <= w_rs_val[7:0];
  end

endmodule

// File: rtl/ren_conv_top_wrapper.sv
// Wishbone slave front end: decodes instance/region/word, generates ack, muxes read data from the engines.
// Latency: ack and read data one cycle after stb&cyc are sampled; a request is not re-sampled during its ack.
// Backpressure: none; every request (including out-of-range) is acked, unmapped reads return 0.
// Ports: wb_clk_i/wb_rst_i clock and sync reset; wbs_* Wishbone slave (sel ignored, full-word accesses).
module ren_conv_top_wrapper
  import ren_conv_pkg::*;
#(
  parameter int NO_OF_INSTS     = 4,
  parameter int KERN_COL_WIDTH  = 3,
  parameter int COL_WIDTH       = 8,
  parameter int KERN_CNT_WIDTH  = 3,
  parameter int IMG_ADDR_WIDTH  = 6,
  parameter int RSLT_ADDR_WIDTH = 6
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);

  logic        r_ack;
  logic [31:0] r_dat;
  logic        w_req;
  logic [7:0]  w_inst;
  region_e     w_region;
  logic [5:0]  w_idx;
  logic [31:0] w_eng_rdat [NO_OF_INSTS];
  logic [31:0] w_sel_rdat;
  logic        w_unused_ok;

  // Field widths are fixed by the register map; kept as parameters for interface compatibility.
  assign w_unused_ok = ^{wbs_sel_i, wbs_adr_i[23:10], wbs_adr_i[1:0],
                         KERN_COL_WIDTH[0], COL_WIDTH[0], KERN_CNT_WIDTH[0]};

  // Masking with r_ack keeps a still-asserted strobe from being taken twice.
  assign w_req    = wbs_stb_i && wbs_cyc_i && !r_ack;
  assign w_inst   = wbs_adr_i[31:24] - INST_BASE;
  assign w_region = region_e'(wbs_adr_i[9:8]);
  assign w_idx    = wbs_adr_i[7:2];

  for (genvar gi = 0; gi < NO_OF_INSTS; gi++) begin : g_eng
    ren_conv_engine #(
      .IMG_ADDR_WIDTH (IMG_ADDR_WIDTH),
      .RSLT_ADDR_WIDTH(RSLT_ADDR_WIDTH)
    ) u_eng (
      .i_clk    (wb_clk_i),
      .i_rst    (wb_rst_i),
      .i_acc_vld(w_req && (w_inst == 8'(gi))),
      .i_we     (wbs_we_i),
      .i_region (w_region),
      .i_idx    (w_idx),
      .i_wdat   (wbs_dat_i),
      .o_rdat   (w_eng_rdat[gi])
    );
  end

  always_comb begin
    w_sel_rdat = '0;
    for (int i = 0; i < NO_OF_INSTS; i++) begin
      if (w_inst == 8'(i)) w_sel_rdat = w_eng_rdat[i];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !wbs_we_i) ? w_sel_rdat : 32'h0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

endmodule

// File: tb/tb_ren_conv_top_wrapper.sv
module tb_ren_conv_top_wrapper;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [31:0] wdat, adr;
  logic        ack;
  logic [31:0] rdat;

  int n_tot = 0;
  int n_bad = 0;
  int ncyc  = 0;
  int ack_wait;

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  ren_conv_top_wrapper dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(4'hF),
    .wbs_dat_i(wdat),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat)
  );

  // Hand-computed results for the common image/kernel setup.
  int exp_pool [12] = '{15, 27, 39, 51, 30, 54, 78, 102, 45, 81, 117, 153};
  int exp_flat [8]  = '{9, 15, 21, 27, 33, 39, 45, 51};
  int exp_k4   [12] = '{42, 66, 90, 114, 84, 132, 180, 228, 126, 198, 14, 86};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_adr(input int inst, input int region, input int idx);
    logic [7:0] b;
    b = 8'(8'h30 + inst);
    return {b, 14'b0, 2'(region), 6'(idx), 2'b00};
  endfunction

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] r);
    logic got;
    got = 1'b0;
    r = '0;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        r = rdat;
        ack_wait = i;
        break;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) chk("ack_timeout", {31'b0, got}, 32'd1);
  endtask

  task automatic wr(input int inst, input int region, input int idx, input logic [31:0] d);
    logic [31:0] r;
    xfer(1'b1, mk_adr(inst, region, idx), d, r);
  endtask

  task automatic rd(input int inst, input int region, input int idx, output logic [31:0] r);
    xfer(1'b0, mk_adr(inst, region, idx), 32'h0, r);
  endtask

  task automatic load(input int inst);
    logic [7:0] k;
    for (int i = 0; i < 16; i++) begin
      wr(inst, 1, i, {8'h00, 8'(i + 2), 8'(i + 1), 8'(i)});
      k = 8'(1 + i / 4);
      wr(inst, 2, i, {8'h00, k, k, k});
    end
  endtask

  task automatic run_job(input int inst, input logic [31:0] c0, input logic [31:0] c1,
                         input int budget);
    logic [31:0] d;
    logic seen;
    int t0;
    wr(inst, 0, 1, c0);
    wr(inst, 0, 2, c1);
    wr(inst, 0, 0, 32'h0);
    wr(inst, 0, 0, 32'h4);
    t0 = ncyc;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      rd(inst, 0, 0, d);
      seen = d[0];
    end
    chk($sformatf("done_i%0d", inst), {31'b0, seen}, 32'd1);
    chk($sformatf("lat_i%0d", inst), {31'b0, ((ncyc - t0) <= budget + 4)}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; wdat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset values and handshake timing.
    rd(0, 0, 0, d); chk("rst_ctrl", d, 32'h0);
    chk("ack_lat", 32'(ack_wait), 32'd0);
    @(posedge clk); #1;
    chk("ack_once", {31'b0, ack}, 32'd0);
    rd(0, 0, 1, d); chk("rst_cfg0", d, 32'h0);

    // Register readback with unused bits masked.
    wr(0, 0, 1, 32'hFFFF_FFFF); rd(0, 0, 1, d); chk("cfg0_rb", d, 32'hFF07_FF07);
    wr(0, 0, 2, 32'hFFFF_FFFF); rd(0, 0, 2, d); chk("cfg1_rb", d, 32'h001F_0FFF);

    load(0);
    rd(0, 1, 5, d); chk("img_rb", d, 32'h0007_0605);
    rd(0, 2, 9, d); chk("kern_rb", d, 32'h0003_0303);

    // Pooled, kern_cols=2.
    run_job(0, 32'h0102_0701, 32'h001E_0003, 64);
    for (int i = 0; i < 12; i++) begin
      rd(0, 3, i, d); chk($sformatf("pool_r%0d", i), d, 32'(exp_pool[i]));
    end

    // No pooling.
    run_job(0, 32'h0102_0701, 32'h001C_0007, 64);
    for (int i = 0; i < 8; i++) begin
      rd(0, 3, i, d); chk($sformatf("flat_r%0d", i), d, 32'(exp_flat[i]));
    end

    // kern_cols=4: third kernel wraps to the low 8 bits.
    run_job(0, 32'h0102_0703, 32'h001E_0003, 112);
    for (int i = 0; i < 12; i++) begin
      rd(0, 3, i, d); chk($sformatf("k4_r%0d", i), d, 32'(exp_k4[i]));
    end

    // Result region is read-only.
    wr(0, 3, 0, 32'hAA); rd(0, 3, 0, d); chk("rslt_wr_drop", d, 32'd42);

    // Clear done, then soft reset.
    wr(0, 0, 0, 32'h0);
    wr(0, 0, 0, 32'h2);
    rd(0, 0, 0, d); chk("srst_done0", d, 32'h2);

    // Abort a running job with soft reset; done must never appear.
    wr(0, 0, 0, 32'h0);
    wr(0, 0, 0, 32'h4);
    wr(0, 0, 0, 32'h2);
    rd(0, 0, 0, d); chk("abort_now", d, 32'h6);
    repeat (150) @(posedge clk);
    rd(0, 0, 0, d); chk("abort_late", d, 32'h6);

    // Restart completes again.
    run_job(0, 32'h0102_0703, 32'h001E_0003, 112);
    rd(0, 3, 10, d); chk("restart_r10", d, 32'd14);

    // Out-of-range instances: acked, read 0.
    wr(15, 0, 1, 32'h1234_5678);
    rd(15, 0, 1, d); chk("oor_3f", d, 32'h0);
    rd(4, 0, 1, d);  chk("oor_34", d, 32'h0);

    // Other instances run the same job independently.
    rd(1, 0, 0, d); chk("i1_idle", d, 32'h0);
    for (int n = 1; n < 4; n++) begin
      load(n);
      run_job(n, 32'h0102_0701, 32'h001E_0003, 64);
      for (int i = 0; i < 12; i++) begin
        rd(n, 3, i, d); chk($sformatf("i%0d_r%0d", n, i), d, 32'(exp_pool[i]));
      end
    end
    rd(0, 3, 10, d); chk("i0_kept", d, 32'd14);
    rd(0, 0, 1, d);  chk("i0_cfg_kept", d, 32'h0102_0703);

    // Hard reset clears registers and done, keeps memories.
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk); rst = 1'b0;
    rd(3, 0, 0, d); chk("hrst_ctrl", d, 32'h0);
    rd(3, 0, 1, d); chk("hrst_cfg0", d, 32'h0);
    rd(3, 3, 0, d); chk("hrst_mem", d, 32'd15);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
